// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled sclk/ss/mosi with one-entry TX and RX buffers.
// rx_valid arrives SYNC+2 clk after the last sclk rise; tx_wr is dropped while tx_full, and an unread byte sets overrun.
module spi_slave #(
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  input  logic          lsb_msb,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          rx_full,
  input  logic          rx_ack,
  output logic          overrun,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          state;
  logic [SYNC-1:0] sclk_sync, ss_sync, mosi_sync;
  logic            sclk_q, ss_q;
  logic            sclk_s, ss_s, mosi_s;
  logic            sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [DW-1:0]   shift_reg, tx_buf, frame_load;
  logic [CW-1:0]   bit_cnt;
  logic            msb_first, first_bit, start_frame;

  assign sclk_s    = sclk_sync[SYNC-1];
  assign ss_s      = ss_sync[SYNC-1];
  assign mosi_s    = mosi_sync[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_rise   = ss_s & ~ss_q;
  assign ss_fall   = ~ss_s & ss_q;

  // Frame setup consumes the TX buffer; an empty buffer sends zeros.
  assign frame_load  = tx_full ? tx_buf : '0;
  assign first_bit   = lsb_msb ? frame_load[DW-1] : frame_load[0];
  assign start_frame = ((state == S_IDLE) && ss_fall) || ((state == S_DONE) && !ss_s);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC-2:0], mosi};
      sclk_q    <= sclk_s;
      ss_q      <= ss_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      tx_buf    <= '0;
      bit_cnt   <= '0;
      msb_first <= 1'b0;
      miso      <= 1'b0;
      tx_full   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_full   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // Write and consume are exclusive: a write needs an empty buffer, a consume only clears a full one.
      if (tx_wr && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (start_frame) begin
        tx_full <= 1'b0;
      end

      if (rx_ack && (state != S_DONE))
        rx_full <= 1'b0;

      if (start_frame) begin
        msb_first <= lsb_msb;
        shift_reg <= frame_load;
        miso      <= first_bit;
      end

      case (state)
        S_IDLE: begin
          if (ss_fall)
            state <= S_SHIFT;
          else
            miso <= 1'b0;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          if (ss_rise) begin
            state   <= S_IDLE;
            miso    <= 1'b0;
            bit_cnt <= '0;
          end else if (sclk_rise) begin
            shift_reg <= msb_first ? {shift_reg[DW-2:0], mosi_s} : {mosi_s, shift_reg[DW-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= S_DONE;
          end else if (sclk_fall && (bit_cnt != '0)) begin
            miso <= msb_first ? shift_reg[DW-1] : shift_reg[0];
          end
        end
        S_DONE: begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
          overrun  <= overrun | (rx_full & ~rx_ack);
          rx_full  <= 1'b1;
          bit_cnt  <= '0;
          if (!ss_s) begin
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
            miso  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus randomized frames against a byte-level model.
module tb_spi_slave;
  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk = 1'b0;
  logic          ss = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          lsb_msb = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_wr = 1'b0;
  logic          tx_full;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_full;
  logic          rx_ack = 1'b0;
  logic          overrun;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int rv_cnt = 0;

  spi_slave #(.DW(DW), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .lsb_msb(lsb_msb), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full), .rx_ack(rx_ack),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid === 1'b1) rv_cnt++;

  task automatic apply_reset();
    @(negedge clk);
    sclk = 1'b0; ss = 1'b1; tx_wr = 1'b0; rx_ack = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_tx(input logic [DW-1:0] d);
    @(negedge clk);
    tx_data = d; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master side: mosi set before each rise, miso sampled just before the rise; bits are placed back
  // at their byte position so the collected value equals the slave's transmitted byte in either order.
  task automatic spi_byte(input logic [DW-1:0] mb, input logic msb, input int nbits,
                          input logic new_lm, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb ? (DW - 1 - i) : i;
      mosi = mb[b];
      repeat (HALF) @(negedge clk);
      mi[b] = miso;
      sclk = 1'b1;
      if (i == 3) lsb_msb = new_lm;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [13:0] zero;
    zero = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({miso, tx_full, rx_data, rx_valid, rx_full, overrun, busy} !== zero)
      $display("FAIL reset_outputs got %b exp %b", {miso, tx_full, rx_data, rx_valid, rx_full, overrun, busy}, zero);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_msb_first();
    logic [DW-1:0] mi;
    int rv0;
    lsb_msb = 1'b1;
    write_tx(8'hA5);
    total++;
    if (tx_full !== 1'b1) $display("FAIL msb_tx_full_set got %b exp 1", tx_full); else passed++;
    rv0 = rv_cnt;
    ss_begin();
    total++;
    if (busy !== 1'b1) $display("FAIL msb_busy got %b exp 1", busy); else passed++;
    spi_byte(8'h3C, 1'b1, 8, 1'b1, mi);
    ss_end();
    total++;
    if (mi !== 8'hA5) $display("FAIL msb_miso got %h exp a5", mi); else passed++;
    total++;
    if (rx_data !== 8'h3C) $display("FAIL msb_rx_data got %h exp 3c", rx_data); else passed++;
    total++;
    if (rv_cnt - rv0 !== 1) $display("FAIL msb_rx_valid_pulses got %0d exp 1", rv_cnt - rv0); else passed++;
    total++;
    if ({tx_full, rx_full, busy} !== 3'b010) $display("FAIL msb_flags got %b exp 010", {tx_full, rx_full, busy}); else passed++;
    ack_rx();
    total++;
    if (rx_full !== 1'b0) $display("FAIL msb_rx_ack got %b exp 0", rx_full); else passed++;
  endtask

  task automatic test_lsb_first();
    logic [DW-1:0] mi;
    lsb_msb = 1'b0;
    write_tx(8'h81);
    ss_begin();
    spi_byte(8'h01, 1'b0, 8, 1'b0, mi);
    ss_end();
    total++;
    if (mi !== 8'h81) $display("FAIL lsb_miso got %h exp 81", mi); else passed++;
    total++;
    if (rx_data !== 8'h01) $display("FAIL lsb_rx_data got %h exp 01", rx_data); else passed++;
    ack_rx();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] mi1, mi2;
    int rv0;
    apply_reset();
    total++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun_clear got %b exp 0", overrun); else passed++;
    lsb_msb = 1'b1;
    write_tx(8'h7E);
    rv0 = rv_cnt;
    ss_begin();
    spi_byte(8'hC4, 1'b1, 8, 1'b1, mi1);
    spi_byte(8'h2B, 1'b1, 8, 1'b1, mi2);
    ss_end();
    total++;
    if (mi1 !== 8'h7E) $display("FAIL b2b_miso1 got %h exp 7e", mi1); else passed++;
    total++;
    if (mi2 !== 8'h00) $display("FAIL b2b_miso2 got %h exp 00", mi2); else passed++;
    total++;
    if (rx_data !== 8'h2B) $display("FAIL b2b_rx_data got %h exp 2b", rx_data); else passed++;
    total++;
    if (rv_cnt - rv0 !== 2) $display("FAIL b2b_rx_valid_pulses got %0d exp 2", rv_cnt - rv0); else passed++;
    total++;
    if ({overrun, rx_full} !== 2'b11) $display("FAIL b2b_overrun got %b exp 11", {overrun, rx_full}); else passed++;
    ack_rx();
  endtask

  task automatic test_abort();
    logic [DW-1:0] mi;
    int rv0;
    lsb_msb = 1'b1;
    ss_begin();
    spi_byte(8'h5A, 1'b1, 8, 1'b1, mi);
    ss_end();
    ack_rx();
    rv0 = rv_cnt;
    ss_begin();
    write_tx(8'hC3);
    spi_byte(8'hFF, 1'b1, 5, 1'b1, mi);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", busy); else passed++;
    ss = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL abort_busy_after got %b exp 0", busy); else passed++;
    repeat (8) @(negedge clk);
    total++;
    if (rv_cnt - rv0 !== 0) $display("FAIL abort_rx_valid got %0d exp 0", rv_cnt - rv0); else passed++;
    total++;
    if (rx_data !== 8'h5A) $display("FAIL abort_rx_data got %h exp 5a", rx_data); else passed++;
    total++;
    if ({tx_full, miso} !== 2'b10) $display("FAIL abort_tx_kept got %b exp 10", {tx_full, miso}); else passed++;
    ss_begin();
    spi_byte(8'h96, 1'b1, 8, 1'b1, mi);
    ss_end();
    total++;
    if (rx_data !== 8'h96) $display("FAIL abort_next_rx got %h exp 96", rx_data); else passed++;
    total++;
    if (mi !== 8'hC3) $display("FAIL abort_next_miso got %h exp c3", mi); else passed++;
    ack_rx();
  endtask

  task automatic test_tx_overwrite();
    logic [DW-1:0] mi;
    write_tx(8'h11);
    write_tx(8'h22);
    total++;
    if (tx_full !== 1'b1) $display("FAIL txow_full got %b exp 1", tx_full); else passed++;
    lsb_msb = 1'b0;
    ss_begin();
    spi_byte(8'h33, 1'b0, 8, 1'b0, mi);
    ss_end();
    total++;
    if (mi !== 8'h11) $display("FAIL txow_miso got %h exp 11", mi); else passed++;
    total++;
    if (tx_full !== 1'b0) $display("FAIL txow_consumed got %b exp 0", tx_full); else passed++;
    ack_rx();
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] mi;
    logic [13:0] zero;
    zero = '0;
    lsb_msb = 1'b1;
    write_tx(8'hFF);
    ss_begin();
    write_tx(8'h99);
    spi_byte(8'hAA, 1'b1, 3, 1'b1, mi);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({miso, tx_full, rx_data, rx_valid, rx_full, overrun, busy} !== zero)
      $display("FAIL rstmid_outputs got %b exp %b", {miso, tx_full, rx_data, rx_valid, rx_full, overrun, busy}, zero);
    else passed++;
    ss = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ss_begin();
    spi_byte(8'hF0, 1'b1, 8, 1'b1, mi);
    ss_end();
    total++;
    if (rx_data !== 8'hF0) $display("FAIL rstmid_rx_data got %h exp f0", rx_data); else passed++;
    total++;
    if (mi !== 8'h00) $display("FAIL rstmid_miso got %h exp 00", mi); else passed++;
    ack_rx();
  endtask

  task automatic test_random();
    logic          m_rx_full, m_ovr, m_tx_full, lm;
    logic [DW-1:0] m_tx, m_rx, mb, d, exp_mi, mi;
    int            m_rv;
    apply_reset();
    m_rx_full = 1'b0; m_ovr = 1'b0; m_tx_full = 1'b0; m_tx = '0; m_rx = '0;
    m_rv = rv_cnt;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        ack_rx();
        m_rx_full = 1'b0;
      end
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        d = DW'($urandom);
        write_tx(d);
        if (!m_tx_full) begin
          m_tx = d;
          m_tx_full = 1'b1;
        end
      end
      lm = 1'($urandom_range(0, 1));
      lsb_msb = lm;
      mb = DW'($urandom);
      exp_mi = m_tx_full ? m_tx : '0;
      m_tx_full = 1'b0;
      ss_begin();
      spi_byte(mb, lm, 8, 1'($urandom_range(0, 1)), mi);
      ss_end();
      m_ovr = m_ovr | m_rx_full;
      m_rx_full = 1'b1;
      m_rx = mb;
      m_rv++;
      total++;
      if (mi !== exp_mi) $display("FAIL rand%0d_miso got %h exp %h", it, mi, exp_mi); else passed++;
      total++;
      if (rx_data !== m_rx) $display("FAIL rand%0d_rx_data got %h exp %h", it, rx_data, m_rx); else passed++;
      total++;
      if (rv_cnt !== m_rv) $display("FAIL rand%0d_rx_valid_count got %0d exp %0d", it, rv_cnt, m_rv); else passed++;
      total++;
      if ({overrun, rx_full, tx_full} !== {m_ovr, m_rx_full, m_tx_full})
        $display("FAIL rand%0d_flags got %b exp %b", it, {overrun, rx_full, tx_full}, {m_ovr, m_rx_full, m_tx_full});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_tx_overwrite();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
